// File: rtl/grid_cell_arbiter_pkg.sv
// Shared definitions for the snake-game cell map.
// Cell-type encoding, grid dimensions, index width, arbiter FSM states
// and the multiplier-free row*40+col index helper.
package grid_cell_arbiter_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        HEAD = 2'b01,
        BODY = 2'b10,
        WALL = 2'b11
    } cell_t;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;
    localparam int IDX_W      = 11;
    localparam int NUM_CELLS  = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_IDLE,
        ST_WRITE
    } arb_state_t;

    // row*40 as (row<<5)+(row<<3); row/col widths cover both pixel-derived
    // and writer-supplied coordinates.
    function automatic logic [IDX_W-1:0] cell_idx(input logic [5:0] row,
                                                  input logic [5:0] col);
        logic [IDX_W-1:0] r;
        r = IDX_W'(row);
        return (r << 5) + (r << 3) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/grid_cell_ram.sv
// Single-port synchronous RAM holding one 2-bit cell type per tile.
// Registered read data (one-cycle read latency); maps onto block RAM.
// Ports: clk, we (write enable), addr, wdata, rdata (registered).
module grid_cell_ram #(
    parameter int AW = 11,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/grid_cell_arbiter.sv
// Owns the 40x30 cell map and shares its single RAM port between the VGA
// read pipeline (active video) and the game-logic writer / clear fill
// (blanking).
// Ports: clk, rst (async, active-high); x_pos/y_pos/vid_active from VGA
// timing; snake = cell type of the pixel presented two cycles earlier;
// wr_req/wr_x/wr_y/wr_type/wr_ack writer handshake; clr_req starts a
// border/interior fill; busy high while the fill runs.
module grid_cell_arbiter #(
    parameter int GRID_W     = grid_cell_arbiter_pkg::GRID_W,
    parameter int GRID_H     = grid_cell_arbiter_pkg::GRID_H,
    parameter int CELL_SHIFT = grid_cell_arbiter_pkg::CELL_SHIFT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic       vid_active,
    output logic [1:0] snake,
    input  logic       wr_req,
    input  logic [5:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [1:0] wr_type,
    output logic       wr_ack,
    input  logic       clr_req,
    output logic       busy
);
    import grid_cell_arbiter_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID_W * GRID_H - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] fill_idx;
    logic [5:0]       fill_col;
    logic [4:0]       fill_row;
    logic             wr_armed;   // wr_req has been seen low since the last ack
    logic             clr_pend;   // clear that arrived while a write was pending
    logic             act_q;

    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [1:0]       ram_wdata;
    logic [1:0]       ram_rdata;

    logic [IDX_W-1:0] disp_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_in_range;
    logic             fill_wall;

    assign disp_idx    = cell_idx(6'(y_pos >> CELL_SHIFT), 6'(x_pos >> CELL_SHIFT));
    assign wr_idx      = cell_idx({1'b0, wr_y}, wr_x);
    assign wr_in_range = (wr_x < 6'(GRID_W)) && (wr_y < 5'(GRID_H));
    assign fill_wall   = (fill_col == 6'd0) || (fill_col == 6'(GRID_W - 1)) ||
                         (fill_row == 5'd0) || (fill_row == 5'(GRID_H - 1));

    // Active video always owns the port; the FSM only touches it in blanking.
    always_comb begin
        ram_addr  = disp_idx;
        ram_we    = 1'b0;
        ram_wdata = wr_type;
        if (!vid_active) begin
            case (state)
                ST_FILL: begin
                    ram_addr  = fill_idx;
                    ram_we    = 1'b1;
                    ram_wdata = fill_wall ? WALL : NONE;
                end
                ST_WRITE: begin
                    ram_addr  = wr_idx;
                    ram_we    = wr_in_range;
                    ram_wdata = wr_type;
                end
                default: ;
            endcase
        end
    end

    grid_cell_ram #(.AW(IDX_W), .DW(2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Stage 1 is the RAM's own address/data register plus act_q; stage 2 is snake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= 1'b0;
            snake <= NONE;
        end else begin
            act_q <= vid_active;
            snake <= act_q ? ram_rdata : NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FILL;
            fill_idx <= '0;
            fill_col <= '0;
            fill_row <= '0;
            busy     <= 1'b1;
            wr_ack   <= 1'b0;
            wr_armed <= 1'b1;
            clr_pend <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            if (!wr_req)
                wr_armed <= 1'b1;
            case (state)
                ST_FILL: begin
                    if (clr_req) begin
                        fill_idx <= '0;
                        fill_col <= '0;
                        fill_row <= '0;
                    end else if (!vid_active) begin
                        if (fill_idx == LAST_IDX) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            fill_idx <= fill_idx + 1'b1;
                            if (fill_col == 6'(GRID_W - 1)) begin
                                fill_col <= '0;
                                fill_row <= fill_row + 1'b1;
                            end else begin
                                fill_col <= fill_col + 1'b1;
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if (clr_req || clr_pend) begin
                        state    <= ST_FILL;
                        busy     <= 1'b1;
                        fill_idx <= '0;
                        fill_col <= '0;
                        fill_row <= '0;
                        clr_pend <= 1'b0;
                    end else if (wr_req && wr_armed) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (clr_req)
                        clr_pend <= 1'b1;
                    if (!vid_active) begin
                        state    <= ST_IDLE;
                        wr_ack   <= 1'b1;
                        wr_armed <= 1'b0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_cell_arbiter.sv
module tb_grid_cell_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic       vid_active = 1'b0;
    logic [1:0] snake;
    logic       wr_req = 1'b0;
    logic [5:0] wr_x = '0;
    logic [4:0] wr_y = '0;
    logic [1:0] wr_type = '0;
    logic       wr_ack;
    logic       clr_req = 1'b0;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [1:0] model [30][40];

    grid_cell_arbiter dut (
        .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
        .vid_active(vid_active), .snake(snake), .wr_req(wr_req),
        .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type), .wr_ack(wr_ack),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Border cells are walls, everything else empty.
    function automatic void model_fill();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                model[r][c] = (r == 0 || r == 29 || c == 0 || c == 39) ? 2'b11 : 2'b00;
    endfunction

    // Drive one cycle of inputs, step past the rising edge.
    task automatic cyc(input logic act, input int x, input int y);
        vid_active = act;
        x_pos = 10'(x);
        y_pos = 10'(y);
        @(posedge clk);
        #1;
    endtask

    // Present one active pixel, then one blanking cycle; returns snake.
    task automatic px_read(input int x, input int y, output logic [1:0] s);
        cyc(1'b1, x, y);
        cyc(1'b0, 0, 0);
        s = snake;
    endtask

    // Run random active/blanking cycles until busy falls; reports how many
    // blanking cycles it took (-1 if it never fell) and acks seen meanwhile.
    task automatic run_fill(output int n, output int acks);
        logic act;
        n = 0;
        acks = 0;
        for (int g = 0; g < 8000; g++) begin
            act = ($urandom_range(0, 3) == 0);
            cyc(act, $urandom_range(0, 639), $urandom_range(0, 479));
            if (!act) n++;
            if (wr_ack) acks++;
            if (!busy) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (snake !== 2'b00) begin bad++; $display("FAIL reset_snake got=%b want=00", snake); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", wr_ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int n, acks;
        run_fill(n, acks);
        total++; if (n !== 1200) begin bad++; $display("FAIL fill_len got=%0d want=1200", n); end
        model_fill();
    endtask

    task automatic test_display();
        logic [1:0] s;
        px_read(0, 0, s);
        total++; if (s !== 2'b11) begin bad++; $display("FAIL disp_0_0 got=%b want=11", s); end
        px_read(320, 240, s);
        total++; if (s !== 2'b00) begin bad++; $display("FAIL disp_320_240 got=%b want=00", s); end
        px_read(639, 479, s);
        total++; if (s !== 2'b11) begin bad++; $display("FAIL disp_639_479 got=%b want=11", s); end
        cyc(1'b0, 0, 0);
        total++; if (snake !== 2'b00) begin bad++; $display("FAIL disp_blank got=%b want=00", snake); end
    endtask

    task automatic test_write_active();
        int early = 0;
        int n = $urandom_range(5, 20);
        wr_x = 6'd20; wr_y = 5'd15; wr_type = 2'b01; wr_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, $urandom_range(0, 639), $urandom_range(0, 479));
            if (wr_ack) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL wr_ack_in_active got=%0d want=0", early); end
        cyc(1'b0, 0, 0);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack_first_blank got=%b want=1", wr_ack); end
        wr_req = 1'b0;
        model[15][20] = 2'b01;
        cyc(1'b0, 0, 0);
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%b want=0", wr_ack); end
        cyc(1'b1, 320, 240);
        cyc(1'b1, 0, 0);
        total++; if (snake !== 2'b01) begin bad++; $display("FAIL lat_320_240 got=%b want=01", snake); end
        cyc(1'b0, 0, 0);
        total++; if (snake !== 2'b11) begin bad++; $display("FAIL lat_0_0 got=%b want=11", snake); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] s;
        logic got = 1'b0;
        wr_x = 6'd45; wr_y = 5'd3; wr_type = 2'b01; wr_req = 1'b1;
        for (int i = 0; i < 6 && !got; i++) begin
            cyc(1'b0, 0, 0);
            got = wr_ack;
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL oor_ack got=%b want=1", got); end
        wr_req = 1'b0;
        cyc(1'b0, 0, 0);
        px_read(639, 55, s);
        total++; if (s !== model[3][39]) begin bad++; $display("FAIL oor_c39_r3 got=%b want=%b", s, model[3][39]); end
        // row 3 col 45 would alias onto row 4 col 5
        px_read(85, 70, s);
        total++; if (s !== model[4][5]) begin bad++; $display("FAIL oor_alias got=%b want=%b", s, model[4][5]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] s;
        logic act;
        int acks = 0, in_active = 0;
        wr_x = 6'd5; wr_y = 5'd5; wr_type = 2'b10; wr_req = 1'b1;
        for (int i = 0; i < 100 && acks == 0; i++) begin
            act = $urandom_range(0, 1) == 1;
            cyc(act, $urandom_range(0, 639), $urandom_range(0, 479));
            if (wr_ack) begin acks++; if (vid_active) in_active++; end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 0, 0);
            if (wr_ack) begin acks++; if (vid_active) in_active++; end
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL b2b_held_acks got=%0d want=1", acks); end
        wr_req = 1'b0;
        cyc(1'b1, 100, 100);
        wr_x = 6'd6; wr_req = 1'b1;
        for (int i = 0; i < 100 && acks < 2; i++) begin
            act = $urandom_range(0, 1) == 1;
            cyc(act, $urandom_range(0, 639), $urandom_range(0, 479));
            if (wr_ack) begin acks++; if (vid_active) in_active++; end
        end
        wr_req = 1'b0;
        cyc(1'b0, 0, 0);
        if (wr_ack) acks++;
        total++; if (acks !== 2) begin bad++; $display("FAIL b2b_acks got=%0d want=2", acks); end
        total++; if (in_active !== 0) begin bad++; $display("FAIL b2b_ack_active got=%0d want=0", in_active); end
        model[5][5] = 2'b10;
        model[5][6] = 2'b10;
        px_read(5 * 16 + 8, 5 * 16 + 8, s);
        total++; if (s !== 2'b10) begin bad++; $display("FAIL b2b_cell_5_5 got=%b want=10", s); end
        px_read(6 * 16 + 1, 5 * 16 + 15, s);
        total++; if (s !== 2'b10) begin bad++; $display("FAIL b2b_cell_6_5 got=%b want=10", s); end
    endtask

    task automatic test_clr_and_wr();
        logic [1:0] s;
        int n, acks;
        logic got = 1'b0;
        wr_x = 6'd7; wr_y = 5'd9; wr_type = 2'b10; wr_req = 1'b1; clr_req = 1'b1;
        cyc(1'b0, 0, 0);
        clr_req = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clrwr_busy got=%b want=1", busy); end
        run_fill(n, acks);
        total++; if (n !== 1200) begin bad++; $display("FAIL clrwr_fill_len got=%0d want=1200", n); end
        total++; if (acks !== 0) begin bad++; $display("FAIL clrwr_ack_in_fill got=%0d want=0", acks); end
        for (int i = 0; i < 8 && !got; i++) begin
            cyc(1'b0, 0, 0);
            got = wr_ack;
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL clrwr_ack got=%b want=1", got); end
        wr_req = 1'b0;
        cyc(1'b0, 0, 0);
        model_fill();
        model[9][7] = 2'b10;
        px_read(7 * 16 + 3, 9 * 16 + 5, s);
        total++; if (s !== 2'b10) begin bad++; $display("FAIL clrwr_cell got=%b want=10", s); end
        px_read(320, 240, s);
        total++; if (s !== 2'b00) begin bad++; $display("FAIL clrwr_cleared got=%b want=00", s); end
    endtask

    task automatic test_rst_midfill();
        logic [1:0] s;
        int n, acks;
        clr_req = 1'b1; cyc(1'b0, 0, 0); clr_req = 1'b0;
        repeat (400) cyc(1'b0, 0, 0);
        clr_req = 1'b1; cyc(1'b0, 0, 0); clr_req = 1'b0;
        run_fill(n, acks);
        total++; if (n !== 1200) begin bad++; $display("FAIL clr_restart_len got=%0d want=1200", n); end
        clr_req = 1'b1; cyc(1'b0, 0, 0); clr_req = 1'b0;
        repeat (600) cyc(1'b0, 0, 0);
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%b want=1", busy); end
        rst = 1'b0;
        run_fill(n, acks);
        total++; if (n !== 1200) begin bad++; $display("FAIL rst_restart_len got=%0d want=1200", n); end
        model_fill();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                if (r == 0 || r == 29 || c == 0 || c == 39) begin
                    px_read(c * 16 + 7, r * 16 + 9, s);
                    total++;
                    if (s !== model[r][c]) begin
                        bad++; $display("FAIL border r=%0d c=%0d got=%b want=%b", r, c, s, model[r][c]);
                    end
                end
    endtask

    task automatic test_display_random();
        logic [1:0] prev_e, e;
        logic act;
        int x, y;
        prev_e = 2'b00;
        // a few random writes first, tracked in the model on ack
        for (int k = 0; k < 4; k++) begin
            wr_x = 6'($urandom_range(0, 39)); wr_y = 5'($urandom_range(0, 29));
            wr_type = 2'($urandom_range(0, 3)); wr_req = 1'b1;
            for (int i = 0; i < 40; i++) begin
                cyc($urandom_range(0, 1) == 1, $urandom_range(0, 639), $urandom_range(0, 479));
                if (wr_ack) begin model[wr_y][wr_x] = wr_type; break; end
            end
            wr_req = 1'b0;
            cyc(1'b0, 0, 0);
        end
        cyc(1'b0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            act = $urandom_range(0, 2) != 0;
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            e = act ? model[y >> 4][x >> 4] : 2'b00;
            cyc(act, x, y);
            if (i > 0) begin
                total++;
                if (snake !== prev_e) begin bad++; $display("FAIL rand_disp i=%0d got=%b want=%b", i, snake, prev_e); end
            end
            prev_e = e;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_display();
        test_write_active();
        test_out_of_range();
        test_back_to_back();
        test_clr_and_wr();
        test_rst_midfill();
        test_display_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
